// File: rtl/ir_sweep_ctrl.sv
// ir_sweep_ctrl
// Schedules one A2D sweep of the eight IR line sensors through the shared SPI
// master every PERIOD clocks. For each sweep it:
//   - turns the emitters on and waits SETTLE clocks;
//   - runs a select transaction and then a read transaction for each channel;
//   - latches the 12-bit results;
//   - pulses IR_vld and updates line_present.
//
// Handshake with the SPI master: wrt is a one-cycle request. It is raised
// only when no transaction is outstanding, and cmd is stable from wrt until
// the matching done. done is a one-cycle completion strobe carrying rd_data.
// done is acted on only in WAIT_CH/WAIT_RD.
//
// Ports:
//   clk, rst_n           50MHz clock, asynchronous active-low reset
//   wrt, cmd[15:0]       transaction request and MOSI word to the SPI master
//   done, rd_data[15:0]  transaction complete and MISO word from the SPI master
//   IR_en                IR emitter enable (high for the whole sweep)
//   IR_R0..3, IR_L0..3   latched 12-bit readings
//   IR_vld               one-cycle strobe: all eight readings refreshed
//   line_present         some reading of the latest sweep exceeds LINE_THRESH
module ir_sweep_ctrl #(
    parameter bit          FAST_SIM    = 1'b1,
    parameter logic [11:0] LINE_THRESH = 12'h400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        IR_en,
    output logic [11:0] IR_R0,
    output logic [11:0] IR_R1,
    output logic [11:0] IR_R2,
    output logic [11:0] IR_R3,
    output logic [11:0] IR_L0,
    output logic [11:0] IR_L1,
    output logic [11:0] IR_L2,
    output logic [11:0] IR_L3,
    output logic        IR_vld,
    output logic        line_present
);

    localparam int PERIOD_CLKS = FAST_SIM ? 2048 : 131072;
    localparam int SETTLE_CLKS = FAST_SIM ? 64 : 4096;
    localparam logic [16:0] PERIOD_LAST = 17'(PERIOD_CLKS - 1);
    localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        WAIT_CH = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state;
    logic [16:0] period_cnt;
    logic [11:0] settle_cnt;
    logic [2:0]  ch;
    logic [11:0] ir_val [8];   // indexed by channel: R0,L0,R1,L1,R2,L2,R3,L3
    logic        wrap;
    logic        over_any;

    // wrap is true on the cycle whose clock edge returns the counter to 0.
    assign wrap = (period_cnt == PERIOD_LAST);

    function automatic logic [15:0] sel_word(input logic [2:0] c);
        return {2'b00, c, 11'h000};
    endfunction

    always_comb begin
        over_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ir_val[i] > LINE_THRESH) over_any = 1'b1;
        end
    end

    // Free-running period counter; keeps counting during a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            ch           <= '0;
            wrt          <= 1'b0;
            cmd          <= '0;
            IR_en        <= 1'b0;
            IR_vld       <= 1'b0;
            line_present <= 1'b0;
            for (int i = 0; i < 8; i++) ir_val[i] <= '0;
        end else begin
            wrt    <= 1'b0;
            IR_vld <= 1'b0;
            case (state)
                IDLE: begin
                    IR_en <= 1'b0;
                    // A wrap seen in any other state is dropped on purpose:
                    // a long sweep simply skips one period.
                    if (wrap) begin
                        IR_en      <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        cmd   <= sel_word(ch);
                        wrt   <= 1'b1;
                        state <= WAIT_CH;
                    end else begin
                        settle_cnt <= settle_cnt + 12'd1;
                    end
                end
                WAIT_CH: begin
                    // Select done; the read reuses the same cmd word.
                    if (done) begin
                        wrt   <= 1'b1;
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (done) begin
                        ir_val[ch] <= rd_data[11:0];
                        if (ch != 3'd7) begin
                            ch    <= ch + 3'd1;
                            cmd   <= sel_word(ch + 3'd1);
                            wrt   <= 1'b1;
                            state <= WAIT_CH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // IR_en, IR_vld and line_present change on the same edge.
                    IR_en        <= 1'b0;
                    IR_vld       <= 1'b1;
                    line_present <= over_any;
                    ch           <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IR_R0 = ir_val[0];
    assign IR_L0 = ir_val[1];
    assign IR_R1 = ir_val[2];
    assign IR_L1 = ir_val[3];
    assign IR_R2 = ir_val[4];
    assign IR_L2 = ir_val[5];
    assign IR_R3 = ir_val[6];
    assign IR_L3 = ir_val[7];

endmodule
